// File: rtl/aes_pkg.sv
// Shared AES types: state layout, byte/row/column index helpers
// and the ShiftRows direction encoding.
package aes_pkg;

    // byte i = bits [8i+7:8i]; row = i mod 4, column = i div 4
    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic {
        AES_FWD = 1'b0,
        AES_INV = 1'b1
    } aes_mode_e;

    function automatic logic [3:0] byte_idx(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return {col, row};
    endfunction

    function automatic logic [1:0] row_of(input logic [3:0] idx);
        return idx[1:0];
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] idx);
        return idx[3:2];
    endfunction

endpackage

// File: rtl/aes_shift_rows_comb.sv
// Combinational AES ShiftRows / InvShiftRows byte permutation.
// Ports: in_bus (128b state), in_inv (0 fwd, 1 inv), out_bus (128b).
module aes_shift_rows_comb
    import aes_pkg::*;
(
    input  logic [127:0] in_bus,
    input  logic         in_inv,
    output logic [127:0] out_bus
);

    aes_state_t in_s;
    aes_state_t out_s;
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;

    assign in_s    = in_bus;
    assign out_bus = out_s;

    // Column arithmetic is 2-bit, so the mod-4 wrap is free.
    always_comb begin
        out_s = in_s;
        r     = '0;
        c     = '0;
        sc    = '0;
        for (int i = 0; i < 16; i++) begin
            r  = row_of(4'(i));
            c  = col_of(4'(i));
            sc = (aes_mode_e'(in_inv) == AES_INV) ? c - r : c + r;
            out_s[i] = in_s[byte_idx(r, sc)];
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows/InvShiftRows with valid/ready handshake, tag sideband.
// Ports: clk, rst (sync, active-high); in_* / out_* handshakes; busy.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int STAGES = 1, // legal 1..4
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [127:0]     in_bus,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_bus,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [127:0]     perm_bus;
    logic [STAGES:0]  rdy;
    logic [STAGES-1:0] vld;
    logic [127:0]     bus_s [STAGES];
    logic [TAG_W-1:0] tag_s [STAGES];

    aes_shift_rows_comb u_comb (
        .in_bus  (in_bus),
        .in_inv  (in_inv),
        .out_bus (perm_bus)
    );

    // Ready ripples back from the consumer; an empty stage is always
    // ready, which lets bubbles collapse under a downstream stall.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0] && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             valid_q;
        logic             valid_d;
        logic [127:0]     bus_q;
        logic [127:0]     bus_d;
        logic [TAG_W-1:0] tag_q;
        logic [TAG_W-1:0] tag_d;
        logic             up_valid;
        logic [127:0]     up_bus;
        logic [TAG_W-1:0] up_tag;

        if (k == 0) begin : g_head
            assign up_valid = in_valid && in_ready;
            assign up_bus   = perm_bus;
            assign up_tag   = in_tag;
        end else begin : g_body
            assign up_valid = vld[k-1];
            assign up_bus   = bus_s[k-1];
            assign up_tag   = tag_s[k-1];
        end

        always_comb begin
            valid_d = valid_q;
            bus_d   = bus_q;
            tag_d   = tag_q;
            if (rdy[k]) begin
                valid_d = up_valid;
                bus_d   = up_bus;
                tag_d   = up_tag;
            end
        end

        // Data and tag need no reset; they are ignored while invalid.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
            bus_q <= bus_d;
            tag_q <= tag_d;
        end

        assign vld[k]   = valid_q;
        assign bus_s[k] = bus_q;
        assign tag_s[k] = tag_q;
    end

    assign out_valid = vld[STAGES-1];
    assign out_bus   = bus_s[STAGES-1];
    assign out_tag   = tag_s[STAGES-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed and randomized bench for aes_shift_rows_pipe.
// Instances: ua (STAGES=1), ub (STAGES=3).
module tb_aes_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst, a_in_valid, a_in_ready, a_in_inv;
    logic [127:0] a_in_bus, a_out_bus;
    logic [3:0]   a_in_tag, a_out_tag;
    logic         a_out_valid, a_out_ready, a_busy;

    logic         b_rst, b_in_valid, b_in_ready, b_in_inv;
    logic [127:0] b_in_bus, b_out_bus;
    logic [3:0]   b_in_tag, b_out_tag;
    logic         b_out_valid, b_out_ready, b_busy;

    aes_shift_rows_pipe #(.STAGES(1), .TAG_W(4)) ua (
        .clk(clk), .rst(a_rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_inv(a_in_inv), .in_bus(a_in_bus), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bus(a_out_bus), .out_tag(a_out_tag), .busy(a_busy)
    );

    aes_shift_rows_pipe #(.STAGES(3), .TAG_W(4)) ub (
        .clk(clk), .rst(b_rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_inv(b_in_inv), .in_bus(b_in_bus), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bus(b_out_bus), .out_tag(b_out_tag), .busy(b_busy)
    );

    int checks = 0;
    int fails  = 0;

    localparam logic [127:0] SEQ_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] SEQ_FWD = 128'h0b06010c07020d08030e09040f0a0500;
    localparam logic [127:0] SEQ_INV = 128'h0306090c0f0205080b0e0104070a0d00;
    localparam logic [127:0] FIPS_IN = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    localparam logic [127:0] FIPS_SR = 128'he598271ef11141b8ae52b4e0305dbfd4;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: out byte (r,c) = in byte (r,(c+/-r) mod 4), integer indexed.
    function automatic logic [127:0] ref_sr(input logic [127:0] x,
                                            input logic inv);
        logic [127:0] y;
        int r, c, s;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            r = j % 4;
            c = j / 4;
            s = inv ? (c - r + 4) % 4 : (c + r) % 4;
            y[8*j +: 8] = x[8*(s*4 + r) +: 8];
        end
        return y;
    endfunction

    function automatic logic [127:0] item(input int i);
        return {4{32'hc0de0000 + 32'(i * 7)}} ^ {16{8'(i)}};
    endfunction

    task automatic send_a(input logic [127:0] bus, input logic inv,
                          input logic [3:0] tag, input logic [127:0] exp,
                          input string name);
        a_in_valid = 1'b1;
        a_in_bus   = bus;
        a_in_inv   = inv;
        a_in_tag   = tag;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk({name, "_valid"}, a_out_valid, 1'b1);
        chk({name, "_bus"}, a_out_bus, exp);
        chk({name, "_tag"}, a_out_tag, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] hb;
        logic [3:0]   ht;
        logic         hv;
        int nsent, nrecv, cyc, lat;
        logic [127:0] q_bus[$];
        logic [3:0]   q_tag[$];

        a_rst = 1'b1; a_in_valid = 1'b0; a_in_inv = 1'b0;
        a_in_bus = '0; a_in_tag = '0; a_out_ready = 1'b1;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_inv = 1'b0;
        b_in_bus = '0; b_in_tag = '0; b_out_ready = 1'b1;

        // ---- STAGES = 1 ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        a_rst = 1'b0;
        #1;
        chk("idle_in_ready", a_in_ready, 1'b1);

        send_a(SEQ_IN, 1'b0, 4'h5, SEQ_FWD, "fwd");
        send_a(SEQ_IN, 1'b1, 4'ha, SEQ_INV, "inv");
        send_a(FIPS_IN, 1'b0, 4'h3, FIPS_SR, "fips");
        send_a(FIPS_SR, 1'b1, 4'hc, FIPS_IN, "roundtrip");

        // back-to-back, mixed modes
        a_in_valid = 1'b1; a_in_bus = SEQ_IN; a_in_inv = 1'b1; a_in_tag = 4'h1;
        @(posedge clk); #1;
        chk("b2b0_bus", a_out_bus, SEQ_INV);
        chk("b2b_in_ready", a_in_ready, 1'b1);
        a_in_bus = SEQ_IN; a_in_inv = 1'b0; a_in_tag = 4'h2;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("b2b1_valid", a_out_valid, 1'b1);
        chk("b2b1_bus", a_out_bus, SEQ_FWD);
        chk("b2b1_tag", a_out_tag, 4'h2);
        @(posedge clk); #1;
        chk("drain_valid", a_out_valid, 1'b0);
        chk("drain_busy", a_busy, 1'b0);

        // single-stage stall: full stage blocks input
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_bus = FIPS_IN; a_in_inv = 1'b0; a_in_tag = 4'h7;
        @(posedge clk); #1;
        a_in_bus = SEQ_IN; a_in_tag = 4'h8;
        #1;
        chk("stall_in_ready", a_in_ready, 1'b0);
        chk("stall_busy", a_busy, 1'b1);
        @(posedge clk); #1;
        chk("stall_hold_bus", a_out_bus, FIPS_SR);
        chk("stall_hold_tag", a_out_tag, 4'h7);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", a_out_valid, 1'b0);

        // ---- STAGES = 3 ----
        b_rst = 1'b0;
        #1;
        chk("b_rst_out_valid", b_out_valid, 1'b0);
        b_in_valid = 1'b1; b_in_bus = FIPS_IN; b_in_inv = 1'b0; b_in_tag = 4'h9;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b_latency", 128'(lat), 128'd3);
        chk("b_lat_bus", b_out_bus, FIPS_SR);
        @(posedge clk); #1;

        // backpressure: consumer stalled for the first 5 cycles
        nsent = 0; nrecv = 0; cyc = 0; hv = 1'b0; hb = '0; ht = '0;
        while (nrecv < 8 && cyc < 200) begin
            b_in_valid  = (nsent < 8);
            b_in_bus    = item(nsent);
            b_in_inv    = nsent[0];
            b_in_tag    = 4'(nsent);
            b_out_ready = (cyc >= 5);
            #1;
            if (cyc < 5)
                chk("bp_in_ready", b_in_ready, (nsent < 3));
            if (hv) begin
                chk("bp_hold_valid", b_out_valid, 1'b1);
                chk("bp_hold_bus", b_out_bus, hb);
                chk("bp_hold_tag", b_out_tag, ht);
            end
            if (b_out_valid && b_out_ready) begin
                chk("bp_tag", b_out_tag, 4'(nrecv));
                chk("bp_bus", b_out_bus, ref_sr(item(nrecv), nrecv[0]));
                nrecv++;
            end
            if (b_in_valid && b_in_ready) nsent++;
            hv = b_out_valid && !b_out_ready;
            hb = b_out_bus;
            ht = b_out_tag;
            @(posedge clk); #1;
            cyc++;
        end
        b_in_valid = 1'b0;
        chk("bp_count", 128'(nrecv), 128'd8);
        repeat (4) @(posedge clk);
        #1;

        // reset with two items in flight
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_bus = SEQ_IN; b_in_tag = 4'h1;
        @(posedge clk); #1;
        b_in_tag = 4'h2;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("mid_busy", b_busy, 1'b1);
        b_rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", b_out_valid, 1'b0);
        chk("mid_rst_busy", b_busy, 1'b0);
        chk("mid_rst_in_ready", b_in_ready, 1'b0);
        b_rst = 1'b0;
        b_out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("mid_no_stale", b_out_valid, 1'b0);
        end

        // random valid/ready against the reference model
        nsent = 0; nrecv = 0; cyc = 0; hv = 1'b0;
        while (nrecv < 10000 && cyc < 60000) begin
            b_in_valid  = ($urandom_range(0, 9) < 7) && (nsent < 10000);
            b_in_bus    = {$urandom, $urandom, $urandom, $urandom};
            b_in_inv    = 1'($urandom);
            b_in_tag    = 4'(nsent);
            b_out_ready = ($urandom_range(0, 9) < 7);
            #1;
            chk("rnd_busy", b_busy, (q_bus.size() != 0));
            if (hv) begin
                chk("rnd_hold_bus", b_out_bus, hb);
                chk("rnd_hold_tag", b_out_tag, ht);
            end
            if (b_out_valid && b_out_ready) begin
                if (q_bus.size() == 0) begin
                    chk("rnd_spurious", b_out_valid, 1'b0);
                end else begin
                    chk("rnd_bus", b_out_bus, q_bus.pop_front());
                    chk("rnd_tag", b_out_tag, q_tag.pop_front());
                end
                nrecv++;
            end
            if (b_in_valid && b_in_ready) begin
                q_bus.push_back(ref_sr(b_in_bus, b_in_inv));
                q_tag.push_back(b_in_tag);
                nsent++;
            end
            hv = b_out_valid && !b_out_ready;
            hb = b_out_bus;
            ht = b_out_tag;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rnd_count", 128'(nrecv), 128'd10000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/aes_shift_rows_pipe.md
AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 1, number of register stages (legal 1..4).
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each state.
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input state present.
REQ-006 SHALL have port in_ready  output  1  block accepts the input this cycle.
REQ-007 SHALL have port in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows, sampled with the input.
REQ-008 SHALL have port in_bus  input  128  AES state; byte i = in_bus[8i+7:8i], row = i mod 4, column = i div 4.
REQ-009 SHALL have port in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_bus  output  128  permuted state, same byte mapping as in_bus.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the presented result.
REQ-014 SHALL have port busy  output  1  high while any stage holds valid data.

Function
REQ-015 SHALL compute, for ShiftRows, out[r][c] = in[r][(c+r) mod 4] for every row r, including row 0 (unchanged).
REQ-016 SHALL compute, for InvShiftRows, out[r][c] = in[r][(c-r) mod 4].
REQ-017 SHALL apply the permutation combinationally before stage 1; later stages only hold data.
REQ-018 SHALL transfer the input when in_valid && in_ready, and the output when out_valid && out_ready.
REQ-019 SHALL produce a result with latency exactly STAGES cycles from acceptance when out_ready stays high.
REQ-020 SHALL compute stage k ready as !valid[k] || ready[k+1], with the last stage's ready = out_ready; in_ready = stage 1 ready.
REQ-021 SHALL collapse bubbles: an empty stage accepts data even while downstream is stalled.
REQ-022 SHALL sustain one transfer per cycle at full throughput with no dead cycle between back-to-back items.
REQ-023 SHALL hold out_bus, out_tag and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL keep in_ready independent of in_valid in the same cycle (no combinational in_valid -> in_ready path).
REQ-025 SHALL allow mixed in_inv values on consecutive items and process each with its own mode.
REQ-026 SHALL never drop, duplicate or reorder items; at most STAGES items are in flight.
REQ-027 SHALL drive busy = OR of all stage valid bits.

Reset
REQ-028 SHALL clear all stage valid bits on rst; out_valid = 0 and busy = 0 in the cycle after rst is sampled high.
REQ-029 SHALL discard in-flight items when rst is asserted mid-operation; no partial result is emitted.
REQ-030 SHALL hold in_ready = 0 while rst is high.
REQ-031 SHALL not require data or tag registers to be reset; out_bus and out_tag are don't-care while out_valid = 0.

Structure
REQ-032 SHALL take the state typedef (16 x 8-bit array), the byte/row/column index helpers and the mode encoding from shared package aes_pkg.
REQ-033 SHALL instantiate one combinational sub-module, aes_shift_rows_comb (128-bit in, in_inv, 128-bit out); the register chain is built with a generate loop over STAGES.

Verification
REQ-034 SHALL cover forward mode: in_bus bytes 0..15 = 00..0f, in_inv = 0, STAGES = 1 -> out bytes 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b, one cycle later.
REQ-035 SHALL cover inverse mode: same input, in_inv = 1 -> out bytes 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03; forward followed by inverse returns the original.
REQ-036 SHALL cover the FIPS-197 App. B round 1 vector: d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
REQ-037 SHALL cover backpressure: STAGES = 3, stream of 8 tagged items, out_ready low for 5 cycles -> in_ready falls after exactly 3 items are held, outputs stay stable, all 8 tags emerge in order.
REQ-038 SHALL cover reset mid-stream: rst high for 1 cycle with 2 items in flight -> out_valid = 0, busy = 0 next cycle, no stale item is emitted afterwards.
REQ-039 SHALL cover random valid/ready toggling with mixed modes against a reference model, checked over 10,000 items.
